operand_gen_pipe: RTL and testbench
===================================

// Module: operand_gen_pipe
// PURPOSE
//  ID-stage operand generator, successor to the combinational operand select.
//  Decodes op/funct from the instruction and selects operand_1/operand_2 from the
//  register file, the immediate, or shamt. The immediate is sign/zero/upper
//  extended by opcode. Resolves RAW hazards against EX/MEM by forwarding or stall.
//  Registers the result into the ID/EX boundary with a valid/ready handshake.
// PARAMETERS
//  DATA_W      32  operand/register width (>=32; imm/shamt extended to DATA_W)
//  REG_ADDR_W  5   register-file address width
//  CNT_W       16  width of saturating hazard-stall counter
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst_n          in   1           asynchronous reset, active-low
//  in_valid       in   1           in_inst valid
//  in_ready       out  1           instruction accepted this cycle when in_valid&&in_ready
//  in_inst        in   32          MIPS instruction word
//  flush          in   1           synchronous kill of ID/EX contents
//  rf_raddr_1/2   out  REG_ADDR_W  rs=inst[25:21], rt=inst[20:16] (combinational)
//  rf_rdata_1/2   in   DATA_W      same-cycle register-file read data
//  ex_wen,ex_is_load in 1          EX-stage pending write / write is a load
//  ex_waddr,ex_wdata in REG_ADDR_W,DATA_W
//  mem_wen        in   1           MEM-stage pending write
//  mem_waddr,mem_wdata in REG_ADDR_W,DATA_W
//  out_valid      out  1           ID/EX register holds a live instruction
//  out_ready      in   1           EX accepts out_* this cycle
//  out_op,out_funct out 6 each     inst[31:26], inst[5:0]
//  out_waddr      out  REG_ADDR_W  rd for SPECIAL, rt for imm ops, 0 otherwise
//  out_operand_1/2 out DATA_W      selected operands
//  stall_cnt      out  CNT_W       cycles with in_valid && hazard, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* =0, stall_cnt=0; a reset mid-stall drops the held inst.
//  - Operand select: ADDIU: op1=rs, op2=sext(imm). ANDI/ORI/XORI: op1=rs, op2=zext(imm).
//    LUI: op1=0, op2={imm,16'b0} (zero above bit 31). SPECIAL shifts (funct 00/02/03):
//    op1=zext(shamt), op2=rt. Other SPECIAL: op1=rs, op2=rt. Any other op: both 0.
//  - Source used: rs for ADDIU/ANDI/ORI/XORI/non-shift SPECIAL; rt for all SPECIAL.
//    Unused sources and address 0 never hazard/forward; r0 always reads 0.
//  - Forward priority per source: EX (if ex_wen && !ex_is_load) > MEM > RF.
//  - hazard = used src !=0 matching ex_waddr with ex_wen&&ex_is_load.
//  - in_ready = !flush && !hazard && (!out_valid || out_ready).
//  - Capture: in_valid&&in_ready -> out_* loaded, out_valid=1 next edge (1-cycle latency).
//    out_valid&&out_ready without capture -> out_valid=0. Stalled/backpressured: out_* hold.
//  - flush: next edge out_valid=0, no capture that cycle, out data don't-care.
//  - stall_cnt += 1 each cycle in_valid && hazard; holds at 2^CNT_W-1.
// CONFIGURATION
//  OPGEN_FWD_EN defined: forwarding and hazard rule as above.
//  OPGEN_FWD_EN undefined: no bypass; operands from rf_rdata only; hazard = used src
//    !=0 matching ex_waddr (ex_wen) or mem_waddr (mem_wen); stall_cnt counts same.
// STRUCTURE
//  Package operand_pkg: opcode/funct constants (OP_SPECIAL, OP_ADDIU, OP_ANDI, OP_ORI,
//    OP_XORI, OP_LUI, FN_SLL/SRL/SRA), imm-extend mode enum {EXT_SIGN,EXT_ZERO,EXT_UPPER}.
//  Sub-module operand_bypass: one per source; addr, used, RF data, EX/MEM ports ->
//    forwarded data + hazard bit. Top holds decode, ID/EX register, handshake, counter.
// TESTING
//  1 ADDIU rs=1(RF=5), imm=0xFFFE -> next cycle op1=5, op2=0xFFFFFFFE, waddr=rt, out_valid=1.
//  2 ORI imm=0x8001 -> op2=0x00008001; LUI imm=0x1234 -> op1=0, op2=0x12340000.
//  3 ADDU rs=rt=3, EX writes 3=0xA, MEM writes 3=0xB -> op1=op2=0xA; with rs=0, EX waddr 0 -> op1=0.
//  4 EX load to r4, next inst uses r4 -> in_ready=0 one cycle, stall_cnt=1, then MEM fwd value.
//  5 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_* stable, no loss/duplication.
//  6 flush while out_valid=1 -> out_valid=0 next cycle; rst_n low mid-stall -> all outputs 0.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared decode definitions for the ID-stage operand generator: MIPS opcode and
// funct constants, operand-select and immediate-extension enums, and the decoder.
package operand_pkg;

  // Primary opcodes, taken from inst[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // SPECIAL funct codes that use shamt as their first operand
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  // How the 16-bit immediate is widened to the datapath width
  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_UPPER
  } ext_mode_e;

  // Source of operand_1
  typedef enum logic [1:0] {
    OP1_ZERO,
    OP1_RS,
    OP1_SHAMT
  } op1_sel_e;

  // Source of operand_2
  typedef enum logic [1:0] {
    OP2_ZERO,
    OP2_RT,
    OP2_IMM
  } op2_sel_e;

  // Destination register field
  typedef enum logic [1:0] {
    WA_NONE,
    WA_RD,
    WA_RT
  } waddr_sel_e;

  // Everything the datapath needs to know about one instruction
  typedef struct packed {
    op1_sel_e   op1_sel;
    op2_sel_e   op2_sel;
    ext_mode_e  ext_mode;
    waddr_sel_e waddr_sel;
    logic       use_rs;
    logic       use_rt;
  } dec_t;

  // True for the three shift-by-immediate SPECIAL functions
  function automatic logic is_shamt_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

  // Map op/funct to operand selects; unknown opcodes produce all-zero operands
  // and touch no sources, so they can never stall the pipe.
  function automatic dec_t decode_inst(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.op1_sel   = OP1_ZERO;
    d.op2_sel   = OP2_ZERO;
    d.ext_mode  = EXT_ZERO;
    d.waddr_sel = WA_NONE;
    d.use_rs    = 1'b0;
    d.use_rt    = 1'b0;
    case (op)
      OP_SPECIAL: begin
        d.op2_sel   = OP2_RT;
        d.use_rt    = 1'b1;
        d.waddr_sel = WA_RD;
        if (is_shamt_shift(funct)) begin
          d.op1_sel = OP1_SHAMT;
        end else begin
          d.op1_sel = OP1_RS;
          d.use_rs  = 1'b1;
        end
      end
      OP_ADDIU: begin
        d.op1_sel   = OP1_RS;
        d.op2_sel   = OP2_IMM;
        d.ext_mode  = EXT_SIGN;
        d.waddr_sel = WA_RT;
        d.use_rs    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.op1_sel   = OP1_RS;
        d.op2_sel   = OP2_IMM;
        d.ext_mode  = EXT_ZERO;
        d.waddr_sel = WA_RT;
        d.use_rs    = 1'b1;
      end
      OP_LUI: begin
        d.op1_sel   = OP1_ZERO;
        d.op2_sel   = OP2_IMM;
        d.ext_mode  = EXT_UPPER;
        d.waddr_sel = WA_RT;
      end
      default: begin
        d.op1_sel = OP1_ZERO;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Per-source bypass network: resolves one register read against the EX and MEM
// pending writes and flags a read-after-write hazard that must stall ID.
// Build option: OPGEN_FWD_EN enables EX/MEM forwarding; without it every
// matching in-flight write stalls and the operand always comes from the RF.
module operand_bypass #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  src_used,
  input  logic [DATA_W-1:0]     rf_rdata,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  mem_wen,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  hazard
);

  logic src_live;
  logic ex_match;
  logic mem_match;

  // r0 and unused fields never take part in hazard or bypass decisions
  assign src_live  = src_used && (src_addr != '0);
  assign ex_match  = src_live && ex_wen  && (ex_waddr  == src_addr);
  assign mem_match = src_live && mem_wen && (mem_waddr == src_addr);

`ifdef OPGEN_FWD_EN
  // A load in EX has no data yet, so only that case stalls
  assign hazard = ex_match && ex_is_load;

  // Youngest producer wins: EX ALU result, then MEM, then the register file
  always_comb begin
    fwd_data = rf_rdata;
    if (src_addr == '0) begin
      fwd_data = '0;
    end else if (ex_match && !ex_is_load) begin
      fwd_data = ex_wdata;
    end else if (mem_match) begin
      fwd_data = mem_wdata;
    end
  end
`else
  logic unused_fwd_inputs;

  // Without a bypass path every in-flight write to the source must drain first
  assign hazard = ex_match || mem_match;

  // Register file only; r0 is forced to zero whatever the array returns
  always_comb begin
    fwd_data = rf_rdata;
    if (src_addr == '0) begin
      fwd_data = '0;
    end
  end

  assign unused_fwd_inputs = ^{ex_is_load, ex_wdata, mem_wdata};
`endif

endmodule

// File: rtl/operand_gen_pipe.sv
// ID-stage operand generator: decodes the instruction, selects operand_1 and
// operand_2 from register file / immediate / shamt, resolves RAW hazards via
// operand_bypass and registers the result into ID/EX with valid/ready.
// Build option: OPGEN_FWD_EN (see operand_bypass) selects forwarding vs
// stall-only hazard handling.
module operand_gen_pipe
  import operand_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_raddr_1,
  output logic [REG_ADDR_W-1:0] rf_raddr_2,
  input  logic [DATA_W-1:0]     rf_rdata_1,
  input  logic [DATA_W-1:0]     rf_rdata_2,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  mem_wen,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            out_op,
  output logic [5:0]            out_funct,
  output logic [REG_ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0]     out_operand_1,
  output logic [DATA_W-1:0]     out_operand_2,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Instruction fields
  logic [5:0]            inst_op;
  logic [5:0]            inst_funct;
  logic [REG_ADDR_W-1:0] inst_rs;
  logic [REG_ADDR_W-1:0] inst_rt;
  logic [REG_ADDR_W-1:0] inst_rd;
  logic [4:0]            inst_shamt;
  logic [15:0]           inst_imm;
  dec_t                  dec;

  assign inst_op    = in_inst[31:26];
  assign inst_funct = in_inst[5:0];
  assign inst_rs    = REG_ADDR_W'(in_inst[25:21]);
  assign inst_rt    = REG_ADDR_W'(in_inst[20:16]);
  assign inst_rd    = REG_ADDR_W'(in_inst[15:11]);
  assign inst_shamt = in_inst[10:6];
  assign inst_imm   = in_inst[15:0];
  assign dec        = decode_inst(inst_op, inst_funct);

  assign rf_raddr_1 = inst_rs;
  assign rf_raddr_2 = inst_rt;

  // Source 0 is rs, source 1 is rt
  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [DATA_W-1:0]     src_rf   [2];
  logic [DATA_W-1:0]     src_data [2];
  logic [1:0]            src_used;
  logic [1:0]            src_hazard;
  logic                  hazard;

  assign src_addr[0] = inst_rs;
  assign src_addr[1] = inst_rt;
  assign src_rf[0]   = rf_rdata_1;
  assign src_rf[1]   = rf_rdata_2;
  assign src_used    = {dec.use_rt, dec.use_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      operand_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
      ) u_bypass (
        .src_addr   (src_addr[gi]),
        .src_used   (src_used[gi]),
        .rf_rdata   (src_rf[gi]),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .fwd_data   (src_data[gi]),
        .hazard     (src_hazard[gi])
      );
    end
  endgenerate

  assign hazard = |src_hazard;

  // Widen the immediate according to the opcode's extension mode
  logic [DATA_W-1:0] imm_ext;
  always_comb begin
    imm_ext = '0;
    case (dec.ext_mode)
      EXT_SIGN:  imm_ext = DATA_W'($signed(inst_imm));
      EXT_ZERO:  imm_ext = DATA_W'(inst_imm);
      EXT_UPPER: imm_ext = DATA_W'({inst_imm, 16'h0000});
      default:   imm_ext = '0;
    endcase
  end

  // Operand and destination select for the instruction currently in ID
  logic [DATA_W-1:0]     op1_sel;
  logic [DATA_W-1:0]     op2_sel;
  logic [REG_ADDR_W-1:0] waddr_sel;
  always_comb begin
    op1_sel   = '0;
    op2_sel   = '0;
    waddr_sel = '0;
    case (dec.op1_sel)
      OP1_RS:    op1_sel = src_data[0];
      OP1_SHAMT: op1_sel = DATA_W'(inst_shamt);
      default:   op1_sel = '0;
    endcase
    case (dec.op2_sel)
      OP2_RT:  op2_sel = src_data[1];
      OP2_IMM: op2_sel = imm_ext;
      default: op2_sel = '0;
    endcase
    case (dec.waddr_sel)
      WA_RD:   waddr_sel = inst_rd;
      WA_RT:   waddr_sel = inst_rt;
      default: waddr_sel = '0;
    endcase
  end

  // ID/EX register state
  logic                  out_valid_q, out_valid_d;
  logic [5:0]            out_op_q, out_op_d;
  logic [5:0]            out_funct_q, out_funct_d;
  logic [REG_ADDR_W-1:0] out_waddr_q, out_waddr_d;
  logic [DATA_W-1:0]     out_op1_q, out_op1_d;
  logic [DATA_W-1:0]     out_op2_q, out_op2_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  capture;

  // Accept only when not flushing, no hazard, and the ID/EX slot is free or draining
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  // Next-state for the ID/EX slot: flush kills, capture fills, consume empties
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_funct_d = out_funct_q;
    out_waddr_d = out_waddr_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      out_op_d    = inst_op;
      out_funct_d = inst_funct;
      out_waddr_d = waddr_sel;
      out_op1_d   = op1_sel;
      out_op2_d   = op2_sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction is held by a hazard
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any held or stalled instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_funct_q <= '0;
      out_waddr_q <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_funct_q <= out_funct_d;
      out_waddr_q <= out_waddr_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_op        = out_op_q;
  assign out_funct     = out_funct_q;
  assign out_waddr     = out_waddr_q;
  assign out_operand_1 = out_op1_q;
  assign out_operand_2 = out_op2_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_operand_gen_pipe.sv
// Directed bench for operand_gen_pipe; expectations follow the OPGEN_FWD_EN
// build setting. Counter width is reduced so saturation is reachable.
module tb_operand_gen_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic          flush;
  logic [AW-1:0] rf_raddr_1, rf_raddr_2;
  logic [DW-1:0] rf_rdata_1, rf_rdata_2;
  logic          ex_wen, ex_is_load;
  logic [AW-1:0] ex_waddr;
  logic [DW-1:0] ex_wdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_op, out_funct;
  logic [AW-1:0] out_waddr;
  logic [DW-1:0] out_operand_1, out_operand_2;
  logic [CW-1:0] stall_cnt;

  logic [31:0] rf [0:31];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  // Register-file model answering the DUT's read addresses
  assign rf_rdata_1 = rf[rf_raddr_1];
  assign rf_rdata_2 = rf[rf_raddr_2];

  operand_gen_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .flush(flush),
    .rf_raddr_1(rf_raddr_1), .rf_raddr_2(rf_raddr_2),
    .rf_rdata_1(rf_rdata_1), .rf_rdata_2(rf_rdata_2),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_funct(out_funct),
    .out_waddr(out_waddr), .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bump_stall();
    exp_stall = (exp_stall == 7) ? 7 : exp_stall + 1;
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'hDEAD_BEEF;
    rf[1] = 32'h5;
    rf[2] = 32'h22;
    rf[3] = 32'h33;
    rf[4] = 32'h44;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0;
    ex_wen = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
    mem_wen = 1'b0; mem_waddr = '0; mem_wdata = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op1", out_operand_1, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    // ADDIU sign extension, 1-cycle latency
    in_valid = 1'b1;
    in_inst = itype(6'h09, 5'd1, 5'd7, 16'hFFFE);
    settle();
    chk("addiu_in_ready", in_ready, 1);
    chk("addiu_raddr1", rf_raddr_1, 1);
    tick();
    chk("addiu_valid", out_valid, 1);
    chk("addiu_op1", out_operand_1, 32'h5);
    chk("addiu_op2", out_operand_2, 32'hFFFF_FFFE);
    chk("addiu_waddr", out_waddr, 7);
    chk("addiu_op", out_op, 6'h09);

    // ORI zero extension
    in_inst = itype(6'h0D, 5'd2, 5'd8, 16'h8001);
    tick();
    chk("ori_op1", out_operand_1, 32'h22);
    chk("ori_op2", out_operand_2, 32'h0000_8001);
    chk("ori_waddr", out_waddr, 8);

    // LUI upper immediate
    in_inst = itype(6'h0F, 5'd2, 5'd9, 16'h1234);
    tick();
    chk("lui_op1", out_operand_1, 0);
    chk("lui_op2", out_operand_2, 32'h1234_0000);
    chk("lui_waddr", out_waddr, 9);

    // SLL: shamt then rt
    in_inst = rtype(5'd0, 5'd2, 5'd10, 5'd5, 6'h00);
    tick();
    chk("sll_op1", out_operand_1, 32'h5);
    chk("sll_op2", out_operand_2, 32'h22);
    chk("sll_waddr", out_waddr, 10);

    // ADDU rs=rt=3 with EX and MEM both writing r3
    in_inst = rtype(5'd3, 5'd3, 5'd11, 5'd0, 6'h21);
    ex_wen = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'hA;
    mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hB;
    settle();
`ifdef OPGEN_FWD_EN
    chk("fwd_in_ready", in_ready, 1);
    tick();
    chk("fwd_op1", out_operand_1, 32'hA);
    chk("fwd_op2", out_operand_2, 32'hA);
    ex_wen = 1'b0; mem_wen = 1'b0;
`else
    chk("raw_in_ready", in_ready, 0);
    tick();
    bump_stall();
    chk("raw_stall", stall_cnt, exp_stall);
    chk("raw_valid", out_valid, 0);
    ex_wen = 1'b0; mem_wen = 1'b0;
    settle();
    chk("raw_in_ready2", in_ready, 1);
    tick();
    chk("raw_op1", out_operand_1, 32'h33);
    chk("raw_op2", out_operand_2, 32'h33);
`endif
    chk("addu_waddr", out_waddr, 11);

    // rs=0 with EX writing r0: r0 stays zero
    in_inst = rtype(5'd0, 5'd3, 5'd12, 5'd0, 6'h21);
    ex_wen = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hA;
    settle();
    chk("r0_in_ready", in_ready, 1);
    tick();
    chk("r0_op1", out_operand_1, 0);
    chk("r0_op2", out_operand_2, 32'h33);
    ex_wen = 1'b0;

    // Load-use on r4
    in_inst = rtype(5'd4, 5'd0, 5'd13, 5'd0, 6'h21);
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'hBAD;
    settle();
    chk("ld_in_ready", in_ready, 0);
    tick();
    bump_stall();
    chk("ld_stall", stall_cnt, exp_stall);
    chk("ld_valid", out_valid, 0);
    ex_wen = 1'b0; ex_is_load = 1'b0;
    mem_wen = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h4444;
    settle();
`ifdef OPGEN_FWD_EN
    chk("ld_in_ready2", in_ready, 1);
    tick();
    chk("ld_op1", out_operand_1, 32'h4444);
`else
    chk("ld_in_ready2", in_ready, 0);
    tick();
    bump_stall();
    chk("ld_stall2", stall_cnt, exp_stall);
    mem_wen = 1'b0;
    tick();
    chk("ld_op1", out_operand_1, 32'h44);
`endif
    mem_wen = 1'b0;
    chk("ld_op2", out_operand_2, 0);
    chk("ld_waddr", out_waddr, 13);

    // Backpressure: held for 3 cycles, then one capture
    out_ready = 1'b0;
    in_inst = itype(6'h09, 5'd1, 5'd14, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_hold_waddr", out_waddr, 13);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_new_waddr", out_waddr, 14);
    chk("bp_new_op1", out_operand_1, 32'h5);
    chk("bp_new_op2", out_operand_2, 32'h1);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", out_valid, 0);

    // ANDI then flush
    in_valid = 1'b1;
    in_inst = itype(6'h0C, 5'd2, 5'd15, 16'hF0F0);
    tick();
    chk("andi_valid", out_valid, 1);
    chk("andi_op1", out_operand_1, 32'h22);
    chk("andi_op2", out_operand_2, 32'h0000_F0F0);
    flush = 1'b1;
    settle();
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0;

    // XORI, then hold it and stall long enough to saturate the counter
    in_inst = itype(6'h0E, 5'd1, 5'd16, 16'hFFFF);
    tick();
    chk("xori_op2", out_operand_2, 32'h0000_FFFF);
    chk("xori_op", out_op, 6'h0E);
    out_ready = 1'b0;
    in_inst = rtype(5'd4, 5'd4, 5'd17, 5'd0, 6'h21);
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd4;
    for (int k = 0; k < 10; k++) begin
      tick();
      bump_stall();
    end
    chk("sat_stall", stall_cnt, exp_stall);
    chk("sat_hold_waddr", out_waddr, 16);

    // Reset in the middle of the stall
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_op1", out_operand_1, 0);
    chk("midrst_op2", out_operand_2, 0);
    chk("midrst_waddr", out_waddr, 0);
    chk("midrst_op", out_op, 0);
    chk("midrst_stall", stall_cnt, 0);
    in_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
